// File: rtl/count_snapshot_pkg.sv
// count_snapshot_pkg: shared widths and the snapshot entry type for the
// counter snapshot FIFO.
package count_snapshot_pkg;

    localparam int CNT_W     = 64;
    localparam int DEPTH_MAX = 16;

    // One captured snapshot: one field per upstream counter.
    typedef struct packed {
        logic [CNT_W-1:0] cnt0;
        logic [CNT_W-1:0] cnt1;
    } snap_entry_t;

    // Pack two counter values into an entry.
    function automatic snap_entry_t make_entry(input logic [CNT_W-1:0] c0,
                                               input logic [CNT_W-1:0] c1);
        snap_entry_t e;
        e.cnt0 = c0;
        e.cnt1 = c1;
        return e;
    endfunction

endpackage

// File: rtl/count_snapshot_fifo.sv
// snap_fifo: register-based DEPTH-entry FIFO of snap_entry_t.
// Push and Pop must already be qualified by the caller. Count, Valid and Full
// are registered. Storage has no reset.
import count_snapshot_pkg::*;

module snap_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Push,
    input  logic                       Pop,
    input  snap_entry_t                WrData,
    output snap_entry_t                RdData,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Valid,
    output logic                       Full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    snap_entry_t      mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             valid_r;
    logic             full_r;

    // Next occupancy: +1 on push only, -1 on pop only, otherwise unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({Push, Pop})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers and status flags; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            if (Push) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (Pop)  rd_ptr_r <= rd_ptr_r + PW'(1);
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != CW'(0));
            full_r  <= (count_nxt_s == CW'(DEPTH));
        end
    end

    // Entry storage write; contents are only meaningful behind a valid pointer.
    always_ff @(posedge Clk) begin
        if (Push) mem_r[wr_ptr_r] <= WrData;
    end

    assign RdData = mem_r[rd_ptr_r];
    assign Count  = count_r;
    assign Valid  = valid_r;
    assign Full   = full_r;

endmodule

// File: rtl/count_snapshot.sv
// count_snapshot: captures {Cnt0,Cnt1} on Snap into a small FIFO, with a
// sticky Drop flag for snapshots lost while full.
// Macro COUNT_SNAPSHOT_DELTA_EN: when defined, entries hold the difference
// from the previously accepted snapshot (modulo 2^64) instead of absolute values.
import count_snapshot_pkg::*;

module count_snapshot #(
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [CNT_W-1:0]           Cnt0,
    input  logic [CNT_W-1:0]           Cnt1,
    input  logic                       Snap,
    input  logic                       Ready,
    input  logic                       ClrDrop,
    output logic                       Valid,
    output logic [CNT_W-1:0]           Data0,
    output logic [CNT_W-1:0]           Data1,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Full,
    output logic                       Drop
);

    logic        pop_s;
    logic        push_s;
    logic        discard_s;
    logic        drop_r;
    snap_entry_t wr_entry_s;
    snap_entry_t rd_entry_s;

    // A full FIFO still accepts a snapshot when the head leaves at the same edge.
    assign pop_s     = Valid & Ready;
    assign push_s    = Snap & (~Full | pop_s);
    assign discard_s = Snap & Full & ~pop_s;

`ifdef COUNT_SNAPSHOT_DELTA_EN
    logic [CNT_W-1:0] base0_r;
    logic [CNT_W-1:0] base1_r;

    // Entry is the distance from the last accepted snapshot, wrapping modulo 2^64.
    always_comb begin
        wr_entry_s = make_entry(Cnt0 - base0_r, Cnt1 - base1_r);
    end

    // Baseline follows accepted pushes only; discarded snapshots leave it alone.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            base0_r <= {CNT_W{1'b0}};
            base1_r <= {CNT_W{1'b0}};
        end else if (push_s) begin
            base0_r <= Cnt0;
            base1_r <= Cnt1;
        end
    end
`else
    // Entry is the absolute counter values.
    always_comb begin
        wr_entry_s = make_entry(Cnt0, Cnt1);
    end
`endif

    // Sticky drop flag; a discard wins over a simultaneous clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            drop_r <= 1'b0;
        end else if (discard_s) begin
            drop_r <= 1'b1;
        end else if (ClrDrop) begin
            drop_r <= 1'b0;
        end
    end

    snap_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk    (Clk),
        .Reset  (Reset),
        .Push   (push_s),
        .Pop    (pop_s),
        .WrData (wr_entry_s),
        .RdData (rd_entry_s),
        .Count  (Count),
        .Valid  (Valid),
        .Full   (Full)
    );

    assign Data0 = rd_entry_s.cnt0;
    assign Data1 = rd_entry_s.cnt1;
    assign Drop  = drop_r;

endmodule

// File: tb/tb_count_snapshot.sv
// tb_count_snapshot: directed, self-checking bench for count_snapshot (DEPTH=4).
module tb_count_snapshot;

    logic        Clk;
    logic        Reset;
    logic [63:0] Cnt0;
    logic [63:0] Cnt1;
    logic        Snap;
    logic        Ready;
    logic        ClrDrop;
    logic        Valid;
    logic [63:0] Data0;
    logic [63:0] Data1;
    logic [2:0]  Count;
    logic        Full;
    logic        Drop;

    int n_checks = 0;
    int n_pass   = 0;

    count_snapshot #(.DEPTH(4)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Cnt0    (Cnt0),
        .Cnt1    (Cnt1),
        .Snap    (Snap),
        .Ready   (Ready),
        .ClrDrop (ClrDrop),
        .Valid   (Valid),
        .Data0   (Data0),
        .Data1   (Data1),
        .Count   (Count),
        .Full    (Full),
        .Drop    (Drop)
    );

    // 10 ns clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_d0 [4];

        Reset = 1'b1; Cnt0 = 64'd0; Cnt1 = 64'd0;
        Snap = 1'b0; Ready = 1'b0; ClrDrop = 1'b0;
        #1;
        chk("rst_count", 64'(Count), 64'd0);
        chk("rst_valid", 64'(Valid), 64'd0);
        chk("rst_full",  64'(Full),  64'd0);
        chk("rst_drop",  64'(Drop),  64'd0);
        step();
        Reset = 1'b0;

        // Single snapshot, consumer always ready.
        Cnt0 = 64'd5; Cnt1 = 64'd2; Snap = 1'b1; Ready = 1'b1;
        step();
        Snap = 1'b0;
        chk("one_valid", 64'(Valid), 64'd1);
        chk("one_d0",    Data0,      64'd5);
        chk("one_d1",    Data1,      64'd2);
        chk("one_count", 64'(Count), 64'd1);
        step();
        chk("one_popped", 64'(Valid), 64'd0);
        chk("one_empty",  64'(Count), 64'd0);

        // Overfill: five snapshots into four entries.
        Ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            Cnt0 = 64'(i); Cnt1 = 64'(i + 100); Snap = 1'b1;
            step();
        end
        Snap = 1'b0;
        chk("ovf_count", 64'(Count), 64'd4);
        chk("ovf_full",  64'(Full),  64'd1);
        chk("ovf_drop",  64'(Drop),  64'd1);
        Ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_drain_d0", Data0, 64'(i));
            chk("ovf_drain_d1", Data1, 64'(i + 100));
            step();
        end
        Ready = 1'b0;
        chk("ovf_empty", 64'(Count), 64'd0);
        chk("ovf_drop_sticky", 64'(Drop), 64'd1);

        // Clear drop, refill, then push and pop at the same edge while full.
        ClrDrop = 1'b1;
        step();
        ClrDrop = 1'b0;
        chk("clr_drop", 64'(Drop), 64'd0);
        for (int i = 11; i <= 14; i++) begin
            Cnt0 = 64'(i); Snap = 1'b1;
            step();
        end
        chk("pp_full_before", 64'(Full), 64'd1);
        Cnt0 = 64'd15; Snap = 1'b1; Ready = 1'b1;
        step();
        Snap = 1'b0; Ready = 1'b0;
        chk("pp_count", 64'(Count), 64'd4);
        chk("pp_full",  64'(Full),  64'd1);
        chk("pp_drop",  64'(Drop),  64'd0);
        Ready = 1'b1;
        for (int i = 12; i <= 15; i++) begin
            chk("pp_drain_d0", Data0, 64'(i));
            step();
        end
        Ready = 1'b0;
        chk("pp_empty", 64'(Count), 64'd0);

        // Discard beats a same-edge clear; a later clear alone works.
        for (int i = 21; i <= 24; i++) begin
            Cnt0 = 64'(i); Snap = 1'b1;
            step();
        end
        Cnt0 = 64'd25; Snap = 1'b1; ClrDrop = 1'b1;
        step();
        Snap = 1'b0;
        chk("clr_vs_discard", 64'(Drop), 64'd1);
        step();
        ClrDrop = 1'b0;
        chk("clr_after", 64'(Drop), 64'd0);
        chk("clr_count", 64'(Count), 64'd4);

        // Build Count=3 with Drop=1, then reset in mid-cycle.
        Snap = 1'b1; Cnt0 = 64'd26;
        step();
        Snap = 1'b0;
        chk("pre_rst_drop", 64'(Drop), 64'd1);
        Ready = 1'b1;
        step();
        Ready = 1'b0;
        chk("pre_rst_count", 64'(Count), 64'd3);
        #2;
        Reset = 1'b1;
        #1;
        chk("mid_rst_count", 64'(Count), 64'd0);
        chk("mid_rst_valid", 64'(Valid), 64'd0);
        chk("mid_rst_drop",  64'(Drop),  64'd0);
        chk("mid_rst_full",  64'(Full),  64'd0);
        Snap = 1'b1; Cnt0 = 64'd99;
        step();
        chk("rst_snap_ignored", 64'(Count), 64'd0);
        Reset = 1'b0;
        Cnt0 = 64'd77;
        step();
        Snap = 1'b0;
        chk("post_rst_push_count", 64'(Count), 64'd1);
        chk("post_rst_push_d0",    Data0,      64'd77);
        Ready = 1'b1;
        step();
        Ready = 1'b0;
        chk("post_rst_empty", 64'(Count), 64'd0);

        // Field contents: absolute, or delta from the last accepted push.
        // Baseline is 77 from the push above in delta mode.
        Cnt0 = 64'd87; Snap = 1'b1;
        step();
        Cnt0 = 64'd112;
        step();
        Cnt0 = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        Cnt0 = 64'd3;
        step();
        Snap = 1'b0;
`ifdef COUNT_SNAPSHOT_DELTA_EN
        exp_d0[0] = 64'd10;
        exp_d0[1] = 64'd25;
        exp_d0[2] = 64'hFFFF_FFFF_FFFF_FF8F;
        exp_d0[3] = 64'd4;
`else
        exp_d0[0] = 64'd87;
        exp_d0[1] = 64'd112;
        exp_d0[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_d0[3] = 64'd3;
`endif
        Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("field_d0", Data0, exp_d0[i]);
            step();
        end
        Ready = 1'b0;
        chk("field_empty", 64'(Count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/count_snapshot.md
COUNT_SNAPSHOT -- requirements
Module: count_snapshot

Interface
REQ-001 Parameter DEPTH SHALL be: DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 Port Clk SHALL be: Clk  input  1  rising-edge clock.
REQ-003 Port Reset SHALL be: Reset  input  1  reset, asynchronous, active-high.
REQ-004 Port Cnt0 SHALL be: Cnt0  input  64  upstream counter 0 value.
REQ-005 Port Cnt1 SHALL be: Cnt1  input  64  upstream counter 1 value.
REQ-006 Port Snap SHALL be: Snap  input  1  capture request, sampled each edge.
REQ-007 Port Ready SHALL be: Ready  input  1  consumer accepts head entry.
REQ-008 Port ClrDrop SHALL be: ClrDrop  input  1  clears sticky Drop.
REQ-009 Port Valid SHALL be: Valid  output  1  head entry present.
REQ-010 Port Data0 SHALL be: Data0  output  64  head entry, counter 0 field.
REQ-011 Port Data1 SHALL be: Data1  output  64  head entry, counter 1 field.
REQ-012 Port Count SHALL be: Count  output  clog2(DEPTH+1)  occupancy.
REQ-013 Port Full SHALL be: Full  output  1  Count==DEPTH.
REQ-014 Port Drop SHALL be: Drop  output  1  sticky lost-snapshot flag.

Function
REQ-015 A push SHALL occur at a rising edge when Snap=1 and (Full=0 or a pop occurs at the same edge).
REQ-016 A pop SHALL occur at a rising edge when Valid=1 and Ready=1; Ready with Valid=0 SHALL have no effect.
REQ-017 A pushed entry SHALL be {Cnt0,Cnt1} as sampled at the push edge, visible on Data0/Data1 no earlier than the next cycle.
REQ-018 Data0/Data1 SHALL be driven from the head entry without added latency; their value when Valid=0 SHALL be don't-care.
REQ-019 Valid SHALL equal (Count!=0); Count SHALL be +1 on push-only, -1 on pop-only, unchanged on push+pop or no event.
REQ-020 When Full=1, Snap=1 and a pop occurs at the same edge, both SHALL be performed and Count SHALL remain DEPTH.
REQ-021 When Full=1, Snap=1 and no pop occurs, the snapshot SHALL be discarded and Drop SHALL be set at that edge.
REQ-022 Push and pop pointers SHALL wrap modulo DEPTH; entry order SHALL be strictly first-in first-out.
REQ-023 ClrDrop=1 SHALL clear Drop at the edge; a discard at the same edge SHALL take priority and leave Drop=1.
REQ-024 Entries SHALL be stored only in registers; there SHALL be no combinational path from Snap to any output.

Reset
REQ-025 On assertion of Reset, Count=0, Valid=0, Full=0, Drop=0, both pointers=0 and the delta baseline=0, all immediately and regardless of Clk.
REQ-026 Entry storage SHALL NOT require a reset.
REQ-027 After Reset deasserts, the first rising edge SHALL accept a push; a Snap arriving while Reset is asserted SHALL be ignored.

Configuration
REQ-028 Macro COUNT_SNAPSHOT_DELTA_EN SHALL select the stored field contents.
REQ-029 With COUNT_SNAPSHOT_DELTA_EN defined, each field SHALL store Cnt minus the baseline, modulo 2^64, with wrap-around allowed.
REQ-030 With COUNT_SNAPSHOT_DELTA_EN defined, the baseline SHALL update to the sampled Cnt only on an accepted push; discarded snapshots SHALL NOT move it.
REQ-031 Without COUNT_SNAPSHOT_DELTA_EN, absolute Cnt values SHALL be stored and no baseline registers SHALL exist.

Structure
REQ-032 Package count_snapshot_pkg SHALL hold CNT_W=64, DEPTH_MAX=16 and typedef snap_entry_t (two CNT_W fields).
REQ-033 A sub-module snap_fifo (generic DEPTH x snap_entry_t, push/pop/count/full) SHALL hold storage; count_snapshot SHALL hold push/drop/delta logic.

Verification
REQ-034 Reset; Cnt0=5, Cnt1=2, Snap one cycle, Ready=1 -> Valid=1 next cycle, Data0=5, Data1=2, then Valid=0.
REQ-035 Ready=0; Snap on 5 consecutive cycles with Cnt0=1..5 -> Count=4, Full=1, Drop=1, drain yields 1,2,3,4.
REQ-036 Full FIFO; Snap=1 and Ready=1 at the same edge -> Count stays 4, Drop stays 0, new entry appears last.
REQ-037 DELTA_EN; Cnt0=10 then Cnt0=25 pushed -> Data0=10 then 15; baseline 2^64-1 with Cnt0=3 -> Data0=4.
REQ-038 Reset asserted mid-cycle with Count=3 and Drop=1 -> Count=0, Valid=0, Drop=0 before the next edge.
REQ-039 ClrDrop=1 at the same edge as a full discard -> Drop=1; ClrDrop=1 next edge without a discard -> Drop=0.
